// File: rtl/uart_tx.sv
// UART transmitter: pops one word from the TX FIFO and sends it as
// start bit, D_W data bits LSB first, optional parity and stop bits.
module uart_tx #(
    parameter int D_W       = 8,
    parameter int B_TICK    = 16,
    parameter int STOP_BITS = 1,
    parameter int PAR_EN    = 0,
    parameter int PAR_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_en,
    input  logic           ff_empty,
    input  logic [D_W-1:0] ff_data,
    output logic           ff_rd_en,
    output logic           tx_data,
    output logic           tx_busy,
    output logic           tx_done
);

    localparam int TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
    localparam int BW = $clog2(D_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t         state;
    logic [TW-1:0]  tick;
    logic [BW-1:0]  bit_cnt;
    logic [D_W-1:0] shreg;
    logic           par;
    logic           in_bit;
    logic           bit_end;

    assign in_bit  = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
    assign bit_end = baud_en && (tick == TW'(B_TICK - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx_data  <= 1'b1;
            ff_rd_en <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (in_bit && baud_en) begin
                tick <= bit_end ? '0 : tick + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    tx_data <= 1'b1;
                    if (!ff_empty) begin
                        ff_rd_en <= 1'b1;
                        tx_busy  <= 1'b1;
                        state    <= LOAD;
                    end
                end
                // First cycle drops the pop; FIFO data is valid on the second.
                LOAD: begin
                    if (ff_rd_en) begin
                        ff_rd_en <= 1'b0;
                    end else begin
                        shreg   <= ff_data;
                        par     <= (^ff_data) ^ 1'(PAR_ODD);
                        tick    <= '0;
                        bit_cnt <= '0;
                        tx_data <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_data <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == BW'(D_W - 1)) begin
                            bit_cnt <= '0;
                            if (PAR_EN != 0) begin
                                tx_data <= par;
                                state   <= PARITY;
                            end else begin
                                tx_data <= 1'b1;
                                state   <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_data <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_data <= 1'b1;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five parameter sets, each fed by its own FIFO model,
// line checked every clock against a bit list built from the data word.
module tb_uart_tx;

    localparam int N = 5;
    localparam int DW [N] = '{8, 8, 8, 8, 5};
    localparam int BT [N] = '{16, 16, 16, 16, 8};
    localparam int SB [N] = '{1, 1, 1, 2, 2};
    localparam int PE [N] = '{0, 1, 1, 0, 1};
    localparam int PO [N] = '{0, 0, 1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_en = 1'b0;
    logic [N-1:0] tx, busy, done, rd, empty;
    logic [8:0] dout [N] = '{default: '0};
    logic [8:0] mem [N][16];
    int wp [N] = '{default: 0};
    int rp [N] = '{default: 0};
    int npop [N] = '{default: 0};
    int bad_rd = 0;
    int cyc = 0;
    int glo = 0;
    int ghi = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_e
        assign empty[g] = (wp[g] == rp[g]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rd[k]) begin
                if (wp[k] == rp[k]) bad_rd <= bad_rd + 1;
                dout[k] <= mem[k][rp[k] % 16];
                rp[k]   <= rp[k] + 1;
                npop[k] <= npop[k] + 1;
            end
        end
    end

    uart_tx #(.D_W(8), .B_TICK(16), .STOP_BITS(1),
              .PAR_EN(0), .PAR_ODD(0)) u0 (
        .clk(clk), .rst(rst), .baud_en(baud_en),
        .ff_empty(empty[0]), .ff_data(dout[0][7:0]),
        .ff_rd_en(rd[0]), .tx_data(tx[0]),
        .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx #(.D_W(8), .B_TICK(16), .STOP_BITS(1),
              .PAR_EN(1), .PAR_ODD(0)) u1 (
        .clk(clk), .rst(rst), .baud_en(baud_en),
        .ff_empty(empty[1]), .ff_data(dout[1][7:0]),
        .ff_rd_en(rd[1]), .tx_data(tx[1]),
        .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx #(.D_W(8), .B_TICK(16), .STOP_BITS(1),
              .PAR_EN(1), .PAR_ODD(1)) u2 (
        .clk(clk), .rst(rst), .baud_en(baud_en),
        .ff_empty(empty[2]), .ff_data(dout[2][7:0]),
        .ff_rd_en(rd[2]), .tx_data(tx[2]),
        .tx_busy(busy[2]), .tx_done(done[2]));

    uart_tx #(.D_W(8), .B_TICK(16), .STOP_BITS(2),
              .PAR_EN(0), .PAR_ODD(0)) u3 (
        .clk(clk), .rst(rst), .baud_en(baud_en),
        .ff_empty(empty[3]), .ff_data(dout[3][7:0]),
        .ff_rd_en(rd[3]), .tx_data(tx[3]),
        .tx_busy(busy[3]), .tx_done(done[3]));

    uart_tx #(.D_W(5), .B_TICK(8), .STOP_BITS(2),
              .PAR_EN(1), .PAR_ODD(1)) u4 (
        .clk(clk), .rst(rst), .baud_en(baud_en),
        .ff_empty(empty[4]), .ff_data(dout[4][4:0]),
        .ff_rd_en(rd[4]), .tx_data(tx[4]),
        .tx_busy(busy[4]), .tx_done(done[4]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int per, output bit b);
        b = !(cyc >= glo && cyc < ghi) && (cyc % per == 0);
        baud_en = b;
        cyc++;
    endtask

    task automatic push(input int k, input logic [8:0] d);
        mem[k][wp[k] % 16] = d;
        wp[k]++;
    endtask

    // Expected line: one list entry per serial bit, each held for
    // B_TICK baud_en pulses counted from the start-bit edge.
    task automatic frame(input int k, input logic [8:0] d,
                         input int per, input int gate,
                         input int abort_at, input bit chained,
                         input bit chain_out);
        bit bits[$];
        bit ok, b, p;
        int idx, cnt, el, lim, nb;
        p = 1'(PO[k]);
        bits.push_back(1'b0);
        for (int i = 0; i < DW[k]; i++) begin
            bits.push_back(d[i]);
            p ^= d[i];
        end
        if (PE[k] != 0) bits.push_back(p);
        for (int i = 0; i < SB[k]; i++) bits.push_back(1'b1);
        nb = bits.size();
        if (!chained) begin
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                ok = rd[k];
                if (ok) chk("busy_pop", busy[k], 1);
                drive(per, b);
            end
            chk("pop_seen", ok, 1);
        end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = !tx[k];
            if (!ok) drive(per, b);
        end
        chk("start_seen", ok, 1);
        glo = cyc + 3;
        ghi = glo + gate;
        idx = 0;
        cnt = 0;
        el = 0;
        lim = nb * BT[k] * per + gate + 50;
        while (idx < nb && el < lim) begin
            if (el > 0) @(negedge clk);
            chk("bit", {tx[k], busy[k], done[k]}, {bits[idx], 2'b10});
            if (idx == abort_at && cnt == 5) begin
                drive(per, b);
                rst = 1'b0;
                @(negedge clk);
                chk("rst_mid", {tx[k], busy[k], rd[k], done[k]}, 4'b1000);
                rst = 1'b1;
                for (int i = 0; i < 40; i++) begin
                    drive(per, b);
                    @(negedge clk);
                    chk("idle_after_rst", {tx[k], busy[k], rd[k]}, 3'b100);
                end
                return;
            end
            drive(per, b);
            el++;
            if (b) begin
                cnt++;
                if (cnt == BT[k]) begin
                    cnt = 0;
                    idx++;
                end
            end
        end
        chk("frame_bound", el < lim, 1);
        @(negedge clk);
        chk("done", {tx[k], busy[k], done[k]}, 3'b101);
        if (per == 1) chk("frame_clks", el, nb * BT[k] + gate);
        drive(per, b);
        if (chain_out) begin
            @(negedge clk);
            chk("pop_next", {rd[k], busy[k], tx[k]}, 3'b111);
            drive(per, b);
        end
    endtask

    initial begin
        logic [8:0] d, m;
        int k, per;
        repeat (3) @(negedge clk);
        chk("reset", {tx, busy, rd, done}, {5'h1f, 15'h0});
        rst = 1'b1;

        push(0, 9'h55);
        frame(0, 9'h55, 1, 0, -1, 1'b0, 1'b0);

        push(0, 9'hA5);
        push(0, 9'h3C);
        frame(0, 9'hA5, 4, 0, -1, 1'b0, 1'b1);
        frame(0, 9'h3C, 4, 0, -1, 1'b1, 1'b0);

        push(1, 9'hA5);
        frame(1, 9'hA5, 1, 0, -1, 1'b0, 1'b0);
        push(2, 9'hA5);
        frame(2, 9'hA5, 1, 0, -1, 1'b0, 1'b0);

        push(3, 9'hFF);
        frame(3, 9'hFF, 1, 0, -1, 1'b0, 1'b0);

        d = 9'($urandom_range(0, 255));
        push(0, d);
        frame(0, d, 1, 50, -1, 1'b0, 1'b0);

        d = 9'($urandom_range(0, 255)) & 9'h1F7;
        push(0, d);
        frame(0, d, 2, 0, 4, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, N - 1);
            per = $urandom_range(1, 3);
            m = (9'h1 << DW[k]) - 9'h1;
            d = 9'($urandom) & m;
            push(k, d);
            frame(k, d, per, 0, -1, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++) chk("pops", npop[i], wp[i]);
        chk("rd_when_empty", bad_rd, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-direction counterpart of uart_rx.
- Sits between the TX-channel fifo instance and the serial output pin inside uart_top.
- Pops one word from the TX FIFO and serialises it onto tx_data as an asynchronous frame: start bit, D_W data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from the shared baud_gen enable, oversampled by B_TICK, exactly as on the receive side.

Parameters:
- D_W, 8: data bits per frame, legal 5..9.
- B_TICK, 16: baud_en pulses per serial bit.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PAR_EN, 0: 1 inserts a parity bit after the data bits.
- PAR_ODD, 0: parity sense when PAR_EN=1; 0 = even, 1 = odd.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-low reset.
- baud_en, input, 1: one-clk pulse at B_TICK x baud rate, from baud_gen b_en.
- ff_empty, input, 1: TX FIFO empty flag.
- ff_data, input, D_W: TX FIFO data_out; valid the cycle after ff_rd_en.
- ff_rd_en, output, 1: one-cycle pop strobe to the TX FIFO.
- tx_data, output, 1: serial line; idles high.
- tx_busy, output, 1: high from the pop cycle until the frame ends.
- tx_done, output, 1: one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (rst=0 at a clk edge): tx_data=1, ff_rd_en=0, tx_busy=0, tx_done=0, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- Reset mid-frame: the line returns high on the next edge and the in-flight word is discarded (not re-queued).
- State machine: IDLE, LOAD, START, DATA, PARITY, STOP, all registered.
- IDLE:
  - tx_data=1.
  - If ff_empty=0: assert ff_rd_en for exactly one cycle, set tx_busy=1, go to LOAD.
  - ff_rd_en is never asserted while ff_empty=1.
- LOAD:
  - Capture ff_data into the shift register and compute parity = XOR(data) XOR PAR_ODD.
  - Clear the tick counter and go to START.
- Bit period rule (START/DATA/PARITY/STOP):
  - The tick counter counts baud_en pulses 0..B_TICK-1.
  - On a baud_en with count==B_TICK-1 the bit ends: counter clears and the state advances. Otherwise the counter increments on baud_en only.
  - tx_data changes only on the edge where a state is entered. Each bit lasts exactly B_TICK baud_en pulses after entry; first-bit phase jitter is at most one baud_en period.
- START: tx_data=0.
- DATA:
  - tx_data = shift register bit 0; the register shifts right at each bit end.
  - The bit counter counts 0..D_W-1. After bit D_W-1, go to PARITY if PAR_EN=1, else STOP.
- PARITY: tx_data = stored parity bit.
- STOP:
  - tx_data=1 for STOP_BITS x B_TICK baud_en pulses.
  - On the final pulse: go to IDLE, pulse tx_done for one cycle, drop tx_busy the same edge.
- Back-to-back frames: with ff_empty=0 on IDLE entry, ff_rd_en asserts on the cycle after tx_done, giving 2 clk of extra idle between frames. No idle bit is inserted beyond that.
- baud_en held low: the FSM freezes in the current bit and tx_data holds its value.
- ff_empty rising mid-frame has no effect on the current frame.
- Total frame = (1 + D_W + PAR_EN + STOP_BITS) x B_TICK baud_en pulses.
- uart_top wiring: ff_rd_en to fifo_tx_rd_en, ff_data to fifo_tx_data_out, ff_empty to fifo_tx_empty, and tx_data becomes a new top-level output.

Test Plan:
- Default params, baud_en high every cycle, FIFO holds 0x55 → one ff_rd_en pulse; tx_data = 0 for 16 clk, then 1,0,1,0,1,0,1,0 at 16 clk each, then 1 for 16; tx_done 160 clk after START entry; ff_rd_en never asserted again.
- FIFO holds 0xA5, 0x3C with baud_en every 4th clk → two contiguous frames LSB first; second ff_rd_en exactly 1 clk after first tx_done; 640 clk per frame; tx_busy stays high except the 1 idle cycle.
- PAR_EN=1, PAR_ODD=0, byte 0xA5 → parity bit 0. Same with PAR_ODD=1 → parity bit 1. Frame is 11 bits (176 baud_en pulses).
- STOP_BITS=2, byte 0xFF → stop-high segment lasts 32 baud_en pulses; tx_done only at its end.
- rst=0 asserted during DATA bit 3 → next edge gives tx_data=1, tx_busy=0, ff_rd_en=0; after release with FIFO empty the line stays idle high.
- baud_en gated low for 50 clk mid-START → tx_data holds 0; bit resumes and completes after the remaining pulses; total pulse count is unchanged.
